// File: rtl/ct_piu_stub_pkg.sv
// ----------------------------------------------------------------------------
// ct_piu_stub_pkg
//   Shared definitions for the PIU-less snoop-response stub: default bus
//   geometry, the response entry layout and the occupancy-counter width helper.
// ----------------------------------------------------------------------------
package ct_piu_stub_pkg;

  localparam int PIU_AC_WIDTH   = 55;
  localparam int PIU_AC_SID_LSB = 5;
  localparam int PIU_SID_W      = 5;
  localparam int PIU_CR_WIDTH   = 10;
  localparam int PIU_RESP_W     = PIU_CR_WIDTH - PIU_SID_W;

  // Head latency timer width; covers RSP_LAT values 0..15.
  localparam int LAT_W = 4;

  // One queued response as it appears on the CR bus: SID in the upper bits.
  typedef struct packed {
    logic [PIU_SID_W-1:0]  sid;
    logic [PIU_RESP_W-1:0] resp;
  } cr_entry_t;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ct_piu_snp_rsp_chan.sv
// ----------------------------------------------------------------------------
// ct_piu_snp_rsp_chan
//   One snoop channel: a DEPTH-entry FIFO of {sid, resp} entries, its
//   occupancy counter and the head latency timer that paces cr_req.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   acvalid       : snoop request valid
//   sid           : SID field already extracted from the AC bus
//   cfg_cr_resp   : response code captured alongside the SID on push
//   ac_grant      : snoop accepted this cycle (combinational)
//   cr_req        : head entry is presented on cr_bus
//   cr_bus        : head entry while cr_req, else zero
//   cr_grant      : response consumed (ignored while cr_req is low)
//   cnt           : current occupancy
// ----------------------------------------------------------------------------
module ct_piu_snp_rsp_chan
  import ct_piu_stub_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter int  SID_W    = PIU_SID_W,
  parameter int  CR_WIDTH = PIU_CR_WIDTH,
  parameter int  RSP_LAT  = 0,
  localparam int CNT_W    = cnt_w(DEPTH),
  localparam int RESP_W   = CR_WIDTH - SID_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acvalid,
  input  logic [SID_W-1:0]    sid,
  input  logic [RESP_W-1:0]   cfg_cr_resp,
  output logic                ac_grant,
  output logic                cr_req,
  output logic [CR_WIDTH-1:0] cr_bus,
  input  logic                cr_grant,
  output logic [CNT_W-1:0]    cnt
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0]  LAT      = LAT_W'(RSP_LAT);

  logic [CR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LAT_W-1:0]    timer;
  logic                push;
  logic                pop;

  // Explicit wrap so non-power-of-2 depths never index past the last slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant looks only at the registered count: a pop in the same cycle does
  // not open a slot until the next cycle.
  assign ac_grant = acvalid && (cnt < FULL_CNT);
  assign push     = ac_grant;

  // Timer holds at zero while empty and restarts on every pop, so it measures
  // cycles since the current head became head.
  assign cr_req   = (cnt != '0) && (timer == LAT);
  assign pop      = cr_req && cr_grant;
  assign cr_bus   = cr_req ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      timer  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase

      if (pop || (cnt == '0)) begin
        timer <= '0;
      end else if (timer != LAT) begin
        timer <= timer + LAT_W'(1);
      end
    end
  end

  // NOTE: entry storage has no reset; slots are only read once the count
  // says they were written, so clearing them would only cost flops.
  always_ff @(posedge clk) begin : storage
    if (push) mem[wr_ptr] <= {sid, cfg_cr_resp};
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && (cnt == '0)));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt == FULL_CNT)));
  a_cnt_range:    assert property (@(posedge clk) disable iff (rst)
    cnt <= FULL_CNT);

endmodule

// File: rtl/ct_piu_snp_rsp_stub.sv
// ----------------------------------------------------------------------------
// ct_piu_snp_rsp_stub
//   Snoop-response stub for PIU-less configurations. Each of NUM_CH snoop
//   sources gets an independent queue that answers every accepted snoop with
//   a clean response {sid, cfg_cr_resp} after RSP_LAT head-wait cycles.
//
// Ports
//   forever_cpuclk   : clock
//   cpurst           : synchronous active-high reset
//   xx_piu_acvalid   : per-channel snoop valid
//   xx_piu_acbus     : snoop buses, channel i at [i*AC_WIDTH +: AC_WIDTH]
//   piu_xx_ac_grant  : per-channel snoop accepted this cycle
//   piu_xx_cr_req    : per-channel response valid
//   piu_xx_cr_bus    : response buses, channel i at [i*CR_WIDTH +: CR_WIDTH]
//   xx_piu_cr_grant  : per-channel response consumed
//   cfg_cr_resp      : response code, captured per snoop at acceptance
//   piu_xx_pend_cnt  : per-channel occupancy
//   piu_xx_no_op     : registered, all channels empty
// ----------------------------------------------------------------------------
module ct_piu_snp_rsp_stub
  import ct_piu_stub_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DEPTH    = 4,
  parameter int AC_WIDTH = PIU_AC_WIDTH,
  parameter int SID_LSB  = PIU_AC_SID_LSB,
  parameter int SID_W    = PIU_SID_W,
  parameter int CR_WIDTH = PIU_CR_WIDTH,
  parameter int RSP_LAT  = 0
) (
  input  logic                                forever_cpuclk,
  input  logic                                cpurst,
  input  logic [NUM_CH-1:0]                   xx_piu_acvalid,
  input  logic [NUM_CH*AC_WIDTH-1:0]          xx_piu_acbus,
  output logic [NUM_CH-1:0]                   piu_xx_ac_grant,
  output logic [NUM_CH-1:0]                   piu_xx_cr_req,
  output logic [NUM_CH*CR_WIDTH-1:0]          piu_xx_cr_bus,
  input  logic [NUM_CH-1:0]                   xx_piu_cr_grant,
  input  logic [CR_WIDTH-SID_W-1:0]           cfg_cr_resp,
  output logic [NUM_CH*cnt_w(DEPTH)-1:0]      piu_xx_pend_cnt,
  output logic                                piu_xx_no_op
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [NUM_CH-1:0] chan_empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    ct_piu_snp_rsp_chan #(
      .DEPTH    (DEPTH),
      .SID_W    (SID_W),
      .CR_WIDTH (CR_WIDTH),
      .RSP_LAT  (RSP_LAT)
    ) u_chan (
      .clk         (forever_cpuclk),
      .rst         (cpurst),
      .acvalid     (xx_piu_acvalid[i]),
      .sid         (xx_piu_acbus[i*AC_WIDTH + SID_LSB +: SID_W]),
      .cfg_cr_resp (cfg_cr_resp),
      .ac_grant    (piu_xx_ac_grant[i]),
      .cr_req      (piu_xx_cr_req[i]),
      .cr_bus      (piu_xx_cr_bus[i*CR_WIDTH +: CR_WIDTH]),
      .cr_grant    (xx_piu_cr_grant[i]),
      .cnt         (piu_xx_pend_cnt[i*CNT_W +: CNT_W])
    );

    assign chan_empty[i] = (piu_xx_pend_cnt[i*CNT_W +: CNT_W] == '0);
  end

  // Idle flag trails the occupancy counters by one cycle.
  always_ff @(posedge forever_cpuclk) begin : no_op_reg
    if (cpurst) piu_xx_no_op <= 1'b1;
    else        piu_xx_no_op <= &chan_empty;
  end

endmodule
